byte_encode_packer: RTL and testbench



---
 rtl/byte_encode_pkg.sv | 37 +++
 rtl/bit_accumulator.sv | 55 +++++
 rtl/byte_encode_packer.sv | 146 ++++++++++++++
 tb/tb_byte_encode_packer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/byte_encode_pkg.sv
// ---------------------------------------------------------------------------
// byte_encode_pkg
// Shared definitions for the ByteEncode_d packer: block geometry, counter
// widths, the sequencer state encoding and two small helpers.
//   bytes_for_d(d) : number of output bytes for a block of D-bit coefficients
//   mask_d(x, d)   : x with every bit at position >= d cleared
// ---------------------------------------------------------------------------
package byte_encode_pkg;

   localparam int MAX_D       = 12;
   localparam int N_COEFF     = 256;
   localparam int ACC_W       = MAX_D + 7;
   localparam int ACC_CNT_W   = 5;
   localparam int COEFF_CNT_W = $clog2(N_COEFF + 1);
   localparam int BYTE_CNT_W  = $clog2((N_COEFF * MAX_D) / 8 + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // N_COEFF is a multiple of 8, so dividing first keeps the product exact.
   function automatic logic [BYTE_CNT_W-1:0] bytes_for_d(input logic [3:0] d);
      return BYTE_CNT_W'((N_COEFF / 8) * int'(d));
   endfunction

   function automatic logic [MAX_D-1:0] mask_d(input logic [MAX_D-1:0] x,
                                                input logic [3:0]       d);
      logic [MAX_D-1:0] m;
      for (int i = 0; i < MAX_D; i++) begin
         m[i] = (i < int'(d));
      end
      return x & m;
   endfunction

endpackage

// File: rtl/bit_accumulator.sv
// ---------------------------------------------------------------------------
// bit_accumulator
// LSB-first bit reservoir for the packer. New coefficient bits are appended
// above the bits already held; whole bytes are removed from the bottom.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_clr           discard all held bits (start of a run)
//   i_push          append i_push_len low bits of i_push_data
//   i_push_data     coefficient, bits above i_push_len are ignored
//   i_push_len      number of bits to append (1..MAX_D)
//   i_pop           drop the lowest 8 bits
//   o_acc_lo        lowest 8 held bits (next byte)
//   o_acc_cnt       number of valid bits held
// The caller never pushes while 8 or more bits are held, so the reservoir
// never exceeds 7 + MAX_D bits. Push and pop are never requested together.
// ---------------------------------------------------------------------------
module bit_accumulator
   import byte_encode_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_push,
   input  logic [MAX_D-1:0]     i_push_data,
   input  logic [3:0]           i_push_len,
   input  logic                 i_pop,
   output logic [7:0]           o_acc_lo,
   output logic [ACC_CNT_W-1:0] o_acc_cnt
);

   logic [ACC_W-1:0]     r_acc;
   logic [ACC_CNT_W-1:0] r_cnt;
   logic [ACC_W-1:0]     w_push_ext;

   // Masked coefficient widened to accumulator width before shifting.
   assign w_push_ext = {7'd0, mask_d(i_push_data, i_push_len)};

   // Reservoir update: clear, append above held bits, or drop one byte.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_acc <= {ACC_W{1'b0}};
         r_cnt <= 5'd0;
      end else if (i_push) begin
         r_acc <= r_acc | (w_push_ext << r_cnt);
         r_cnt <= r_cnt + {1'b0, i_push_len};
      end else if (i_pop) begin
         r_acc <= r_acc >> 8;
         r_cnt <= r_cnt - 5'd8;
      end
   end

   assign o_acc_lo  = r_acc[7:0];
   assign o_acc_cnt = r_cnt;

endmodule

// File: rtl/byte_encode_packer.sv
// ---------------------------------------------------------------------------
// byte_encode_packer
// Packs N_COEFF coefficients of D bits (D = 1..MAX_D, chosen per run) into an
// LSB-first byte stream (Kyber ByteEncode_d). Coefficient i bit j lands in
// stream bit i*D+j; byte k bit m is stream bit 8k+m.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_start          request a run (sampled only when idle)
//   i_d_sel          coefficient width D, latched on an accepted start
//   i_coeff_valid    coefficient source valid
//   o_coeff_ready    packer takes the coefficient this cycle
//   i_coeff_in       coefficient, only bits [D-1:0] used
//   o_byte_valid     byte sink valid
//   i_byte_ready     sink takes the byte this cycle
//   o_byte_out       packed byte
//   o_busy           run in progress
//   o_done           one-cycle pulse after the last byte
//   o_err            one-cycle pulse after a start with illegal D
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module byte_encode_packer
   import byte_encode_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [3:0]       i_d_sel,
   input  logic             i_coeff_valid,
   output logic             o_coeff_ready,
   input  logic [MAX_D-1:0] i_coeff_in,
   output logic             o_byte_valid,
   input  logic             i_byte_ready,
   output logic [7:0]       o_byte_out,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [3:0]             r_d;
   logic [COEFF_CNT_W-1:0] r_coeff_cnt;
   logic [BYTE_CNT_W-1:0]  r_byte_cnt;
   logic                   r_err;

   logic                   w_d_ok;
   logic                   w_clr;
   logic                   w_coeff_ready;
   logic                   w_byte_valid;
   logic                   w_push;
   logic                   w_pop;
   logic [7:0]             w_acc_lo;
   logic [ACC_CNT_W-1:0]   w_acc_cnt;

   assign w_d_ok = (i_d_sel != 4'd0) && (i_d_sel <= 4'(MAX_D));

   bit_accumulator u_acc (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (w_clr),
      .i_push      (w_push),
      .i_push_data (i_coeff_in),
      .i_push_len  (r_d),
      .i_pop       (w_pop),
      .o_acc_lo    (w_acc_lo),
      .o_acc_cnt   (w_acc_cnt)
   );

   // Next-state, handshake and accumulator control decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr         = 1'b0;
      w_coeff_ready = 1'b0;
      w_byte_valid  = 1'b0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start && w_d_ok) begin
               w_clr       = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            // Below 8 held bits we only fill; at 8 or more we only drain,
            // so the two handshakes are mutually exclusive by construction.
            w_coeff_ready = (w_acc_cnt < 5'd8) &&
                            (r_coeff_cnt < COEFF_CNT_W'(N_COEFF));
            w_byte_valid  = (w_acc_cnt >= 5'd8);
            w_push        = w_coeff_ready && i_coeff_valid;
            w_pop         = w_byte_valid && i_byte_ready;
            // The final byte leaves the accumulator empty since N*D is
            // byte-aligned, so counting bytes is enough to end the run.
            if (w_pop && ((r_byte_cnt + BYTE_CNT_W'(1)) == bytes_for_d(r_d))) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, width latch, run counters and error pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_d         <= 4'd0;
         r_coeff_cnt <= {COEFF_CNT_W{1'b0}};
         r_byte_cnt  <= {BYTE_CNT_W{1'b0}};
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= (r_state == IDLE) && i_start && !w_d_ok;
         if (w_clr) begin
            r_d         <= i_d_sel;
            r_coeff_cnt <= {COEFF_CNT_W{1'b0}};
            r_byte_cnt  <= {BYTE_CNT_W{1'b0}};
         end else begin
            if (w_push) begin
               r_coeff_cnt <= r_coeff_cnt + COEFF_CNT_W'(1);
            end
            if (w_pop) begin
               r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
            end
         end
      end
   end

   // Unheld accumulator bits are always zero, so the low byte reads 0
   // whenever no byte is pending (including straight after reset).
   assign o_coeff_ready = w_coeff_ready;
   assign o_byte_valid  = w_byte_valid;
   assign o_byte_out    = w_acc_lo;
   assign o_busy        = (r_state == RUN);
   assign o_done        = (r_state == DONE);
   assign o_err         = r_err;

endmodule

// File: tb/tb_byte_encode_packer.sv
// ---------------------------------------------------------------------------
// tb_byte_encode_packer
// Directed bench for byte_encode_packer. Expected streams come from a
// bit-by-bit reference of ByteEncode_d plus hand-computed constants.
// ---------------------------------------------------------------------------
module tb_byte_encode_packer;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [3:0]  i_d_sel;
   logic        i_coeff_valid;
   logic        o_coeff_ready;
   logic [11:0] i_coeff_in;
   logic        o_byte_valid;
   logic        i_byte_ready;
   logic [7:0]  o_byte_out;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   byte_encode_packer dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_d_sel       (i_d_sel),
      .i_coeff_valid (i_coeff_valid),
      .o_coeff_ready (o_coeff_ready),
      .i_coeff_in    (i_coeff_in),
      .o_byte_valid  (o_byte_valid),
      .i_byte_ready  (i_byte_ready),
      .o_byte_out    (o_byte_out),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int          n_checks;
   int          n_fail;
   logic [11:0] cmem [256];
   logic [7:0]  got  [384];
   logic [7:0]  keep [384];
   logic [7:0]  expb [384];
   int          n_got;
   int          stab_viol;
   int          both_viol;
   logic        first_ready;
   logic        timed_out;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference ByteEncode_d: place every coefficient bit at its stream index.
   task automatic build_exp(input logic [3:0] d);
      int pos;
      for (int k = 0; k < 384; k++) expb[k] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < int'(d); j++) begin
            pos = i * int'(d) + j;
            expb[pos / 8][pos % 8] = cmem[i][j];
         end
      end
   endtask

   // Drive one run; optional stalls, junk upper bits, mid-run start, abort.
   task automatic do_run(input logic [3:0] d, input bit stall, input bit junk,
                         input bit mid_start, input int abort_at);
      int          ci;
      logic        pv;
      logic [7:0]  pb;
      logic        fin;
      logic [11:0] jm;
      ci = 0; n_got = 0; pv = 1'b0; pb = 8'h00; fin = 1'b0;
      jm = 12'hFFF;
      jm = jm << d;
      i_d_sel = d; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      first_ready = o_coeff_ready;
      for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
         if (abort_at != 0 && ci == abort_at) break;
         i_coeff_valid = (ci < 256) && (!stall || ($urandom_range(0, 2) != 0));
         i_coeff_in    = (ci < 256) ? (cmem[ci] | (junk ? jm : 12'h000)) : 12'h000;
         i_byte_ready  = !stall || ($urandom_range(0, 2) == 0);
         i_start       = mid_start && (cyc == 40);
         i_d_sel       = (mid_start && (cyc == 40)) ? 4'd2 : d;
         if (pv && !(o_byte_valid && (o_byte_out == pb))) stab_viol++;
         if (o_coeff_ready && o_byte_valid) both_viol++;
         if (o_done) fin = 1'b1;
         if (i_coeff_valid && o_coeff_ready) ci++;
         if (o_byte_valid && i_byte_ready) begin
            if (n_got < 384) got[n_got] = o_byte_out;
            n_got++;
         end
         pv = o_byte_valid && !i_byte_ready;
         pb = o_byte_out;
         @(negedge i_clk);
      end
      i_coeff_valid = 1'b0; i_byte_ready = 1'b0; i_start = 1'b0;
      timed_out = (abort_at == 0) && !fin;
   endtask

   task automatic check_stream(input string tag, input logic [3:0] d);
      int nb;
      int mism;
      nb = 32 * int'(d);
      build_exp(d);
      mism = 0;
      for (int k = 0; k < nb; k++) begin
         if (got[k] !== expb[k]) mism++;
      end
      check_val({tag, "_timeout"}, 32'(timed_out), 32'd0);
      check_val({tag, "_nbytes"}, 32'(n_got), 32'(nb));
      check_val({tag, "_data_mism"}, 32'(mism), 32'd0);
      check_val({tag, "_done_busy_after"}, 32'({o_done, o_busy}), 32'd0);
   endtask

   initial begin
      int mism;
      n_checks = 0; n_fail = 0; stab_viol = 0; both_viol = 0;
      i_rst = 1'b1; i_start = 1'b0; i_d_sel = 4'd0; i_coeff_valid = 1'b0;
      i_coeff_in = 12'h000; i_byte_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      check_val("reset_outputs",
                32'({o_coeff_ready, o_byte_valid, o_byte_out, o_busy, o_done, o_err}), 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // D=4: 5,A alternating packs to 0xA5 in every byte.
      for (int i = 0; i < 256; i++) cmem[i] = (i % 2 == 0) ? 12'h005 : 12'h00A;
      do_run(4'd4, 1'b0, 1'b0, 1'b0, 0);
      check_val("d4_ready_after_start", 32'(first_ready), 32'd1);
      check_val("d4_byte0", 32'(got[0]), 32'h0A5);
      check_val("d4_byte127", 32'(got[127]), 32'h0A5);
      check_stream("d4", 4'd4);

      // D=12: 0xABC,0x123 lead to 0xBC,0x3A,0x12.
      for (int i = 0; i < 256; i++) cmem[i] = 12'($urandom);
      cmem[0] = 12'hABC; cmem[1] = 12'h123;
      do_run(4'd12, 1'b0, 1'b0, 1'b0, 0);
      check_val("d12_byte0", 32'(got[0]), 32'h0BC);
      check_val("d12_byte1", 32'(got[1]), 32'h03A);
      check_val("d12_byte2", 32'(got[2]), 32'h012);
      check_stream("d12", 4'd12);

      // D=1: a single set bit per 8 coefficients gives 0x01 bytes.
      for (int i = 0; i < 256; i++) cmem[i] = (i % 8 == 0) ? 12'h001 : 12'h000;
      do_run(4'd1, 1'b0, 1'b0, 1'b0, 0);
      check_val("d1_byte0", 32'(got[0]), 32'h001);
      check_val("d1_byte31", 32'(got[31]), 32'h001);
      check_stream("d1", 4'd1);

      // D=11 random, upper bit of each stored coefficient left random.
      for (int i = 0; i < 256; i++) cmem[i] = 12'($urandom);
      do_run(4'd11, 1'b0, 1'b0, 1'b0, 0);
      check_stream("d11", 4'd11);

      // D=10: clean run, then stalled run with junk upper bits and a stray start.
      for (int i = 0; i < 256; i++) cmem[i] = 12'($urandom) & 12'h3FF;
      do_run(4'd10, 1'b0, 1'b0, 1'b0, 0);
      check_stream("d10_clean", 4'd10);
      for (int k = 0; k < 384; k++) keep[k] = got[k];
      stab_viol = 0; both_viol = 0;
      do_run(4'd10, 1'b1, 1'b1, 1'b1, 0);
      check_stream("d10_stall", 4'd10);
      mism = 0;
      for (int k = 0; k < 320; k++) if (got[k] !== keep[k]) mism++;
      check_val("d10_stall_vs_clean", 32'(mism), 32'd0);
      check_val("d10_hold_stable", 32'(stab_viol), 32'd0);
      check_val("d10_ready_valid_excl", 32'(both_viol), 32'd0);

      // Illegal widths: err pulse only.
      i_d_sel = 4'd0; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check_val("err_d0_pulse", 32'({o_err, o_busy, o_byte_valid}), 32'h4);
      @(negedge i_clk);
      check_val("err_d0_clear", 32'({o_err, o_busy, o_byte_valid}), 32'h0);
      i_d_sel = 4'd13; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check_val("err_d13_pulse", 32'({o_err, o_busy, o_coeff_ready}), 32'h4);
      @(negedge i_clk);
      check_val("err_d13_clear", 32'({o_err, o_busy, o_coeff_ready}), 32'h0);

      // Reset after 50 coefficients at D=5, then a clean D=3 run.
      for (int i = 0; i < 256; i++) cmem[i] = 12'($urandom) & 12'h01F;
      do_run(4'd5, 1'b0, 1'b0, 1'b0, 50);
      i_rst = 1'b1;
      @(negedge i_clk);
      check_val("midrun_reset_outputs",
                32'({o_coeff_ready, o_byte_valid, o_byte_out, o_busy, o_done, o_err}), 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      for (int i = 0; i < 256; i++) cmem[i] = 12'($urandom) & 12'h007;
      do_run(4'd3, 1'b0, 1'b0, 1'b0, 0);
      check_stream("d3_after_reset", 4'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
